// File: rtl/sound_latch_irq.sv
// ---------------------------------------------------------------------------
// sound_latch_irq
//
// Byte mailbox from the 68000 main CPU to the Z80 sound CPU, plus the Z80's
// periodic timer interrupt.
//
// The 68000 writes a byte into the latch. The Z80 reads it through I/O port
// 0x06, or clears it through I/O port 0x04. A free-running divider on the
// Z80 clock enable raises INT once every IRQ_DIV Z80 clocks. The Z80 drops
// that request with an interrupt-acknowledge cycle.
//
// Every strobe is edge-detected in the clk domain, so one bus cycle causes
// exactly one action however many clk cycles it lasts.
//
// Parameters
//   IRQ_DIV           z80_cen pulses per timer interrupt (2..65535)
//
// Ports
//   clk               system clock, all state changes on its rising edge
//   reset             asynchronous, active-high reset
//   z80_cen           Z80 clock enable, one clk wide per Z80 clock
//   m68k_dout[7:0]    68000 data bus low byte
//   m68k_rw           68000 R/W (1 = read)
//   m68k_lds_n        68000 lower data strobe, active low
//   sound_latch_cs    decoded 68000 sound-latch select (AS-qualified)
//   z80_rd_n          Z80 RD, active low
//   z80_wr_n          Z80 WR, active low
//   z80_m1_n          Z80 M1, active low
//   z80_iorq_n        Z80 IORQ, active low
//   z80_latch_r_cs    decoded Z80 I/O read select (port 0x06)
//   z80_latch_clr_cs  decoded Z80 I/O clear select (port 0x04)
//   latch_dout[7:0]   registered latch contents for the Z80 data-in mux
//   latch_pending     1 = byte written by the 68000 and not yet consumed
//   z80_irq_n         Z80 INT, active low, registered
// ---------------------------------------------------------------------------
module sound_latch_irq #(
  parameter int unsigned IRQ_DIV = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       z80_cen,
  input  logic [7:0] m68k_dout,
  input  logic       m68k_rw,
  input  logic       m68k_lds_n,
  input  logic       sound_latch_cs,
  input  logic       z80_rd_n,
  input  logic       z80_wr_n,
  input  logic       z80_m1_n,
  input  logic       z80_iorq_n,
  input  logic       z80_latch_r_cs,
  input  logic       z80_latch_clr_cs,
  output logic [7:0] latch_dout,
  output logic       latch_pending,
  output logic       z80_irq_n
);

  localparam logic [15:0] DIV_LAST = 16'(IRQ_DIV - 1);

  // Level strobes decoded from the two buses.
  logic write_strobe;
  logic read_strobe;
  logic clear_strobe;
  logic ack_strobe;

  assign write_strobe = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
  assign read_strobe  = z80_latch_r_cs & ~z80_rd_n;
  assign clear_strobe = z80_latch_clr_cs & ~z80_wr_n;
  assign ack_strobe   = ~z80_m1_n & ~z80_iorq_n;

  // Previous-cycle strobe levels. These reset to 0, so a strobe that is
  // already high in the first clk after reset counts as a fresh edge.
  logic write_q;
  logic read_q;
  logic clear_q;
  logic ack_q;

  // NOTE: state registers use non-blocking assignments, so every always_ff
  // block sees the values from before this edge, whatever order it runs in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
      clear_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      write_q <= write_strobe;
      read_q  <= read_strobe;
      clear_q <= clear_strobe;
      ack_q   <= ack_strobe;
    end
  end

  logic write_rise;
  logic read_rise;
  logic clear_rise;
  logic ack_rise;

  assign write_rise = write_strobe & ~write_q;
  assign read_rise  = read_strobe  & ~read_q;
  assign clear_rise = clear_strobe & ~clear_q;
  assign ack_rise   = ack_strobe   & ~ack_q;

  // -------------------------------------------------------------------------
  // Mailbox latch
  // -------------------------------------------------------------------------
  logic [7:0] latch_q;
  logic       pending_q;

  // The write is tested first. A 68000 write that lands in the same clk as
  // a Z80 read or clear keeps the new byte and leaves it pending, so the
  // Z80 does not lose the message. A second write simply overwrites.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q   <= 8'h00;
      pending_q <= 1'b0;
    end else if (write_rise) begin
      latch_q   <= m68k_dout;
      pending_q <= 1'b1;
    end else if (clear_rise) begin
      latch_q   <= 8'h00;
      pending_q <= 1'b0;
    end else if (read_rise) begin
      pending_q <= 1'b0;
    end
  end

  assign latch_dout    = latch_q;
  assign latch_pending = pending_q;

  // -------------------------------------------------------------------------
  // Timer divider and interrupt request
  // -------------------------------------------------------------------------
  logic [15:0] tick_cnt;
  logic [15:0] tick_cnt_next;
  logic        tick_wrap;

  // NOTE: every output of a combinational block gets a default first. A path
  // that leaves an output unassigned would infer a latch.
  always_comb begin
    tick_cnt_next = tick_cnt;
    tick_wrap     = 1'b0;
    if (z80_cen) begin
      if (tick_cnt == DIV_LAST) begin
        tick_cnt_next = 16'h0000;
        tick_wrap     = 1'b1;
      end else begin
        tick_cnt_next = tick_cnt + 16'h0001;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= 16'h0000;
    end else begin
      tick_cnt <= tick_cnt_next;
    end
  end

  // The request is a single flag, so repeated wraps never stack up. A wrap
  // in the same clk as an acknowledge keeps the request set, because that
  // acknowledge was for the previous request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z80_irq_n <= 1'b1;
    end else if (tick_wrap) begin
      z80_irq_n <= 1'b0;
    end else if (ack_rise) begin
      z80_irq_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sound_latch_irq.sv
// ---------------------------------------------------------------------------
// tb_sound_latch_irq
//
// Directed stimulus for sound_latch_irq with IRQ_DIV = 512, and z80_cen high
// on every 4th clk counted from reset release.
//
// A behavioural model runs beside the DUT. It counts Z80 clock enables since
// reset, and it applies the mailbox and interrupt rules to edges of the bus
// strobes. A compare process checks the DUT against the model on every clk
// that is outside reset.
//
// Literal expectations pin the model itself: the captured bytes, and the clk
// numbers at which INT falls.
// ---------------------------------------------------------------------------
module tb_sound_latch_irq;

  localparam int unsigned IRQ_DIV = 512;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       z80_cen = 1'b0;
  logic [7:0] m68k_dout = 8'h00;
  logic       m68k_rw = 1'b1;
  logic       m68k_lds_n = 1'b1;
  logic       sound_latch_cs = 1'b0;
  logic       z80_rd_n = 1'b1;
  logic       z80_wr_n = 1'b1;
  logic       z80_m1_n = 1'b1;
  logic       z80_iorq_n = 1'b1;
  logic       z80_latch_r_cs = 1'b0;
  logic       z80_latch_clr_cs = 1'b0;
  logic [7:0] latch_dout;
  logic       latch_pending;
  logic       z80_irq_n;

  int checks = 0;
  int failures = 0;

  // Number of clk rising edges since reset was released.
  int cyc = 0;

  sound_latch_irq #(.IRQ_DIV(IRQ_DIV)) dut (
    .clk              (clk),
    .reset            (reset),
    .z80_cen          (z80_cen),
    .m68k_dout        (m68k_dout),
    .m68k_rw          (m68k_rw),
    .m68k_lds_n       (m68k_lds_n),
    .sound_latch_cs   (sound_latch_cs),
    .z80_rd_n         (z80_rd_n),
    .z80_wr_n         (z80_wr_n),
    .z80_m1_n         (z80_m1_n),
    .z80_iorq_n       (z80_iorq_n),
    .z80_latch_r_cs   (z80_latch_r_cs),
    .z80_latch_clr_cs (z80_latch_clr_cs),
    .latch_dout       (latch_dout),
    .latch_pending    (latch_pending),
    .z80_irq_n        (z80_irq_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // z80_cen generator. The enable is high at the edges numbered 4, 8, 12 and
  // so on after reset release, so the 512th enable falls on edge 2048.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc     = 0;
      z80_cen = 1'b0;
    end else begin
      #1;
      cyc     = cyc + 1;
      z80_cen = (cyc % 4) == 3;
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [7:0] m_latch;
  logic       m_pending;
  logic       m_irq;
  int         m_cens;
  logic       p_ws, p_rs, p_cs, p_ack;
  logic       m_ws, m_rs, m_cs, m_ack, m_wrap;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_latch = 8'h00; m_pending = 1'b0; m_irq = 1'b0; m_cens = 0;
      p_ws = 1'b0; p_rs = 1'b0; p_cs = 1'b0; p_ack = 1'b0;
    end else begin
      m_ws  = sound_latch_cs && !m68k_rw && !m68k_lds_n;
      m_rs  = z80_latch_r_cs && !z80_rd_n;
      m_cs  = z80_latch_clr_cs && !z80_wr_n;
      m_ack = !z80_m1_n && !z80_iorq_n;
      // An interrupt is due each time the total enable count reaches a
      // multiple of IRQ_DIV.
      m_wrap = 1'b0;
      if (z80_cen) begin
        m_cens++;
        m_wrap = (m_cens % IRQ_DIV) == 0;
      end
      if (m_ws && !p_ws) begin
        m_latch = m68k_dout; m_pending = 1'b1;
      end else if (m_cs && !p_cs) begin
        m_latch = 8'h00; m_pending = 1'b0;
      end else if (m_rs && !p_rs) begin
        m_pending = 1'b0;
      end
      if (m_wrap) m_irq = 1'b1;
      else if (m_ack && !p_ack) m_irq = 1'b0;
      p_ws = m_ws; p_rs = m_rs; p_cs = m_cs; p_ack = m_ack;
    end
  end

  // Compare process: checks the DUT against the model on each falling edge
  // outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_latch_dout", 32'(latch_dout), 32'(m_latch));
      check("model_pending", 32'(latch_pending), 32'(m_pending));
      check("model_irq_n", 32'(z80_irq_n), 32'(!m_irq));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 20000 && cyc < n; i++) tick();
    if (cyc != n) check("wait_cycle_budget", 32'(cyc), 32'(n));
  endtask

  task automatic set_ws(input logic on, input logic [7:0] d);
    m68k_dout      = d;
    sound_latch_cs = on;
    m68k_rw        = !on;
    m68k_lds_n     = !on;
  endtask

  task automatic set_rs(input logic on);
    z80_latch_r_cs = on;
    z80_rd_n       = !on;
  endtask

  task automatic set_cs(input logic on);
    z80_latch_clr_cs = on;
    z80_wr_n         = !on;
  endtask

  task automatic set_ack(input logic on);
    z80_m1_n   = !on;
    z80_iorq_n = !on;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    ticks(3);
    check("reset_latch", 32'(latch_dout), 32'h00);
    check("reset_pending", 32'(latch_pending), 32'h0);
    check("reset_irq_n", 32'(z80_irq_n), 32'h1);
    reset = 1'b0;

    // Hold a 4-clk write of 0xA5. The byte is captured after 1 clk, and the
    // later data change inside the same bus cycle is ignored.
    tick();
    set_ws(1'b1, 8'hA5);
    tick();
    check("ws_capture_data", 32'(latch_dout), 32'hA5);
    check("ws_capture_pending", 32'(latch_pending), 32'h1);
    m68k_dout = 8'h11;
    ticks(3);
    set_ws(1'b0, 8'h00);
    tick();
    check("ws_single_capture", 32'(latch_dout), 32'hA5);

    // A Z80 read consumes the byte but leaves the data in place. A Z80
    // clear then zeroes the latch.
    set_rs(1'b1);
    tick();
    check("rs_pending_clear", 32'(latch_pending), 32'h0);
    check("rs_data_kept", 32'(latch_dout), 32'hA5);
    set_rs(1'b0);
    tick();
    set_cs(1'b1);
    tick();
    check("cs_zeroes_latch", 32'(latch_dout), 32'h00);
    set_cs(1'b0);
    tick();

    // A write and a clear on the same clk: the write wins.
    set_ws(1'b1, 8'h3C);
    set_cs(1'b1);
    tick();
    check("ws_cs_same_data", 32'(latch_dout), 32'h3C);
    check("ws_cs_same_pending", 32'(latch_pending), 32'h1);
    set_ws(1'b0, 8'h00);
    set_cs(1'b0);
    tick();

    // A second write while the byte is still pending overwrites it.
    set_ws(1'b1, 8'h6B);
    tick();
    set_ws(1'b0, 8'h00);
    tick();
    check("overwrite_data", 32'(latch_dout), 32'h6B);
    check("overwrite_pending", 32'(latch_pending), 32'h1);

    // A write and a read on the same clk: the write wins. The read is then
    // held high, so no further read edge occurs.
    set_ws(1'b1, 8'h7E);
    set_rs(1'b1);
    tick();
    check("ws_rs_same_pending", 32'(latch_pending), 32'h1);
    set_ws(1'b0, 8'h00);
    ticks(2);
    check("rs_held_no_edge", 32'(latch_pending), 32'h1);
    set_rs(1'b0);
    tick();

    // Timer: INT first falls at edge 2048 after reset release.
    wait_cyc(2047);
    check("irq_before_2048", 32'(z80_irq_n), 32'h1);
    tick();
    check("irq_at_2048", 32'(z80_irq_n), 32'h0);

    // An acknowledge edge at edge 2050 clears the request.
    wait_cyc(2049);
    set_ack(1'b1);
    tick();
    check("irq_acked", 32'(z80_irq_n), 32'h1);
    set_ack(1'b0);

    // An acknowledge edge coincides with the wrap at edge 4096. The new
    // request wins.
    wait_cyc(4095);
    check("irq_before_4096", 32'(z80_irq_n), 32'h1);
    set_ack(1'b1);
    tick();
    check("irq_wrap_vs_ack", 32'(z80_irq_n), 32'h0);
    set_ack(1'b0);
    tick();
    set_ack(1'b1);
    tick();
    check("irq_late_ack", 32'(z80_irq_n), 32'h1);
    set_ack(1'b0);

    // Left unacknowledged, the request sets at edge 6144 and stays set
    // across the wrap at edge 8192.
    wait_cyc(6144);
    check("irq_at_6144", 32'(z80_irq_n), 32'h0);
    wait_cyc(8200);
    check("irq_unacked_stays", 32'(z80_irq_n), 32'h0);

    // Reset with a byte pending and INT asserted. A write bus cycle is in
    // progress as reset arrives.
    set_ws(1'b1, 8'h77);
    tick();
    set_ws(1'b0, 8'h00);
    tick();
    check("pre_reset_data", 32'(latch_dout), 32'h77);
    check("pre_reset_pending", 32'(latch_pending), 32'h1);
    @(posedge clk);
    #3;
    set_ws(1'b1, 8'h99);
    reset = 1'b1;
    #1;
    check("async_reset_latch", 32'(latch_dout), 32'h00);
    check("async_reset_pending", 32'(latch_pending), 32'h0);
    check("async_reset_irq_n", 32'(z80_irq_n), 32'h1);
    ticks(3);
    reset = 1'b0;

    // The write strobe is already high in the first clk after release, so
    // it is captured as a new edge.
    tick();
    check("post_reset_capture", 32'(latch_dout), 32'h99);
    check("post_reset_pending", 32'(latch_pending), 32'h1);
    set_ws(1'b0, 8'h00);

    // After reset the counter starts again from 0.
    wait_cyc(2047);
    check("restart_before_2048", 32'(z80_irq_n), 32'h1);
    tick();
    check("restart_at_2048", 32'(z80_irq_n), 32'h0);
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
